// File: rtl/register_alias_table.sv
// register_alias_table
//   Register alias table for a 4-register / 4-entry-ROB out-of-order core.
//   Each architectural register tracks whether its committed value is
//   current or whether a ROB entry (tag) is still going to produce it.
//   A reservation-station lookup returns either the pending producer tag
//   or the committed 16-bit value, registered one cycle after the request.
//
// Ports
//   i_clk           clock, all state changes on the rising edge
//   i_rstn          asynchronous active-low reset
//   i_rob_valid     rename strobe (one rename per cycle)
//   i_rob_addr      ROB tag being allocated
//   i_rob_dst_addr  architectural destination of that ROB entry
//   i_rs_req        operand lookup strobe
//   i_rs_addr       architectural register being looked up
//   o_rs_tag_valid  register is renamed, o_rs_tag is meaningful
//   o_rs_tag        ROB tag of the pending producer
//   o_rs_val_valid  register not renamed, o_rs_val is meaningful
//   o_rs_val        committed register value

module register_alias_table (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_rob_valid,
    input  logic [1:0]  i_rob_addr,
    input  logic [1:0]  i_rob_dst_addr,
    input  logic        i_rs_req,
    input  logic [1:0]  i_rs_addr,
    output logic        o_rs_tag_valid,
    output logic [1:0]  o_rs_tag,
    output logic        o_rs_val_valid,
    output logic [15:0] o_rs_val
);

    logic [3:0]  valid_q, valid_d;
    logic [15:0] val_q [4];
    logic [15:0] val_d [4];
    logic [1:0]  tag_q [4];
    logic [1:0]  tag_d [4];

    logic        tag_valid_q, tag_valid_d;
    logic [1:0]  rs_tag_q, rs_tag_d;
    logic        val_valid_q, val_valid_d;
    logic [15:0] rs_val_q, rs_val_d;

    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < 4; i++) begin
            val_d[i] = val_q[i];
            tag_d[i] = tag_q[i];
        end
        tag_valid_d = 1'b0;
        rs_tag_d    = '0;
        val_valid_d = 1'b0;
        rs_val_d    = '0;

        // Last writer wins: a later rename simply overwrites the tag.
        if (i_rob_valid) begin
            valid_d[i_rob_dst_addr] = 1'b0;
            tag_d[i_rob_dst_addr]   = i_rob_addr;
        end

        // Lookup reads the pre-rename state (no bypass from this edge's rename).
        if (i_rs_req) begin
            if (valid_q[i_rs_addr]) begin
                val_valid_d = 1'b1;
                rs_val_d    = val_q[i_rs_addr];
            end else begin
                tag_valid_d = 1'b1;
                rs_tag_d    = tag_q[i_rs_addr];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q <= '1;
            for (int unsigned i = 0; i < 4; i++) begin
                val_q[i] <= 16'(i);
                tag_q[i] <= '0;
            end
            tag_valid_q <= 1'b0;
            rs_tag_q    <= '0;
            val_valid_q <= 1'b0;
            rs_val_q    <= '0;
        end else begin
            valid_q <= valid_d;
            for (int unsigned i = 0; i < 4; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
            tag_valid_q <= tag_valid_d;
            rs_tag_q    <= rs_tag_d;
            val_valid_q <= val_valid_d;
            rs_val_q    <= rs_val_d;
        end
    end

    assign o_rs_tag_valid = tag_valid_q;
    assign o_rs_tag       = rs_tag_q;
    assign o_rs_val_valid = val_valid_q;
    assign o_rs_val       = rs_val_q;

endmodule

// File: tb/tb_register_alias_table.sv
module tb_register_alias_table;

    logic        clk;
    logic        rstn;
    logic        rob_valid;
    logic [1:0]  rob_addr;
    logic [1:0]  rob_dst;
    logic        rs_req;
    logic [1:0]  rs_addr;
    logic        tag_valid;
    logic [1:0]  tag;
    logic        val_valid;
    logic [15:0] val;

    int passed = 0;
    int total  = 0;

    register_alias_table dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_rob_valid    (rob_valid),
        .i_rob_addr     (rob_addr),
        .i_rob_dst_addr (rob_dst),
        .i_rs_req       (rs_req),
        .i_rs_addr      (rs_addr),
        .o_rs_tag_valid (tag_valid),
        .o_rs_tag       (tag),
        .o_rs_val_valid (val_valid),
        .o_rs_val       (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", name, got, exp);
    endtask

    task automatic chk4(input string name, input logic tv, input logic [1:0] t,
                        input logic vv, input logic [15:0] v);
        chk({name, ".tag_valid"}, {15'd0, tag_valid}, {15'd0, tv});
        chk({name, ".tag"},       {14'd0, tag},       {14'd0, t});
        chk({name, ".val_valid"}, {15'd0, val_valid}, {15'd0, vv});
        chk({name, ".val"},       val,                v);
    endtask

    // Drive one cycle of stimulus, clock it, and leave time just after the edge.
    task automatic cyc(input logic rv, input logic [1:0] ra, input logic [1:0] rd,
                       input logic rq, input logic [1:0] qa);
        rob_valid = rv;
        rob_addr  = ra;
        rob_dst   = rd;
        rs_req    = rq;
        rs_addr   = qa;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rs_req deliberately left undriven during the first phase.
        rstn      = 1'b0;
        rob_valid = 1'b0;
        rob_addr  = '0;
        rob_dst   = '0;
        rs_addr   = '0;
        #12;
        chk4("reset", 1'b0, 2'd0, 1'b0, 16'h0000);
        rstn = 1'b1;

        // Renames with an undriven lookup strobe: outputs must stay quiet.
        rob_valid = 1'b1; rob_addr = 2'd2; rob_dst = 2'd1;
        @(posedge clk); #1;
        chk4("xreq0", 1'b0, 2'd0, 1'b0, 16'h0000);
        rob_addr = 2'd3; rob_dst = 2'd2;
        @(posedge clk); #1;
        chk4("xreq1", 1'b0, 2'd0, 1'b0, 16'h0000);
        rob_valid = 1'b0;
        @(posedge clk); #1;
        chk4("xreq2", 1'b0, 2'd0, 1'b0, 16'h0000);

        // Reset again so the directed sequence starts from a clean table.
        rs_req = 1'b0;
        rstn   = 1'b0;
        #4;
        rstn = 1'b1;

        cyc(1'b0, 2'd0, 2'd0, 1'b1, 2'd1);
        chk4("lookup_r1_reset", 1'b0, 2'd0, 1'b1, 16'h0001);

        cyc(1'b1, 2'd3, 2'd0, 1'b0, 2'd0);
        chk4("idle_rename0", 1'b0, 2'd0, 1'b0, 16'h0000);
        cyc(1'b1, 2'd1, 2'd0, 1'b0, 2'd0);
        cyc(1'b1, 2'd2, 2'd3, 1'b0, 2'd0);

        cyc(1'b0, 2'd0, 2'd0, 1'b1, 2'd0);
        chk4("lookup_r0_lastwriter", 1'b1, 2'd1, 1'b0, 16'h0000);
        cyc(1'b0, 2'd0, 2'd0, 1'b1, 2'd3);
        chk4("lookup_r3_tag2", 1'b1, 2'd2, 1'b0, 16'h0000);
        cyc(1'b0, 2'd0, 2'd0, 1'b1, 2'd1);
        chk4("lookup_r1_val", 1'b0, 2'd0, 1'b1, 16'h0001);

        cyc(1'b1, 2'd0, 2'd2, 1'b1, 2'd2);
        chk4("same_edge_r2_old", 1'b0, 2'd0, 1'b1, 16'h0002);
        cyc(1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
        chk4("next_edge_r2_tag0", 1'b1, 2'd0, 1'b0, 16'h0000);

        cyc(1'b0, 2'd0, 2'd0, 1'b0, 2'd3);
        chk4("req_gap", 1'b0, 2'd0, 1'b0, 16'h0000);
        cyc(1'b0, 2'd0, 2'd0, 1'b1, 2'd3);
        chk4("after_gap_r3", 1'b1, 2'd2, 1'b0, 16'h0000);

        // Fresh reset, then rename every register while looking up.
        rs_req = 1'b0;
        rstn   = 1'b0;
        #4;
        rstn = 1'b1;
        cyc(1'b1, 2'd0, 2'd0, 1'b1, 2'd1);
        chk4("all_ren0_r1", 1'b0, 2'd0, 1'b1, 16'h0001);
        cyc(1'b1, 2'd1, 2'd1, 1'b1, 2'd1);
        chk4("all_ren1_r1_pre", 1'b0, 2'd0, 1'b1, 16'h0001);
        cyc(1'b1, 2'd2, 2'd2, 1'b1, 2'd0);
        chk4("all_ren2_r0", 1'b1, 2'd0, 1'b0, 16'h0000);
        cyc(1'b1, 2'd3, 2'd3, 1'b1, 2'd1);
        chk4("all_ren3_r1", 1'b1, 2'd1, 1'b0, 16'h0000);

        // Asynchronous reset mid-cycle with a lookup still requested.
        rob_valid = 1'b0;
        rs_addr   = 2'd3;
        #2;
        rstn = 1'b0;
        #1;
        chk4("async_reset", 1'b0, 2'd0, 1'b0, 16'h0000);
        @(negedge clk);
        rstn = 1'b1;

        cyc(1'b0, 2'd0, 2'd0, 1'b1, 2'd3);
        chk4("post_reset_r3", 1'b0, 2'd0, 1'b1, 16'h0003);
        cyc(1'b0, 2'd0, 2'd0, 1'b1, 2'd0);
        chk4("post_reset_r0", 1'b0, 2'd0, 1'b1, 16'h0000);
        cyc(1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
        chk4("post_reset_r2", 1'b0, 2'd0, 1'b1, 16'h0002);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
